// File: rtl/fleet_placement_checker_if.sv
// Placement request / fleet RAM / status response bundle for fleet_placement_checker.
// slave = checker side, master = requester plus RAM side.
interface fleet_placement_checker_if #(
    parameter int COORD_W   = 4,
    parameter int MAX_CELLS = 5,
    parameter int SLOTS     = 11,
    parameter int PLAYERS   = 2
);
    localparam int ENTRY_W = 3 + 2*COORD_W*MAX_CELLS + 4;
    localparam int PW      = (PLAYERS > 2) ? $clog2(PLAYERS) : 1;
    localparam int AW      = $clog2(SLOTS);

    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_tipo;
    logic               req_dir;
    logic [1:0]         req_orient;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic [PW-1:0]      req_player;

    logic [PW-1:0]      rd_player;
    logic [AW-1:0]      rd_addr;
    logic [ENTRY_W-1:0] rd_data;

    logic               mem_we;
    logic [PW-1:0]      mem_wr_player;
    logic [AW-1:0]      mem_wr_addr;
    logic [ENTRY_W-1:0] mem_wr_data;

    logic               rsp_valid;
    logic               rsp_ok;
    logic               rsp_err_border;
    logic               rsp_err_overlap;
    logic               rsp_err_full;

    modport slave (
        input  req_valid, req_tipo, req_dir, req_orient, req_x, req_y, req_player, rd_data,
        output req_ready, rd_player, rd_addr, mem_we, mem_wr_player, mem_wr_addr, mem_wr_data,
               rsp_valid, rsp_ok, rsp_err_border, rsp_err_overlap, rsp_err_full
    );
    modport master (
        output req_valid, req_tipo, req_dir, req_orient, req_x, req_y, req_player, rd_data,
        input  req_ready, rd_player, rd_addr, mem_we, mem_wr_player, mem_wr_addr, mem_wr_data,
               rsp_valid, rsp_ok, rsp_err_border, rsp_err_overlap, rsp_err_full
    );
endinterface

// File: rtl/fleet_placement_checker.sv
// Expands a ship placement, checks border/full/overlap against the player's fleet RAM, stores it.
// Latency accept->rsp_valid: 2 on border/full, used+3 on overlap, used+4 on success.
// One request in flight; req_ready low from accept until RESP. ADJACENCY_CHECK_EN: diagonal/side touch counts as overlap.
module fleet_placement_checker #(
    parameter int COORD_W   = 4,
    parameter int BOARD_DIM = 10,
    parameter int MAX_CELLS = 5,
    parameter int SLOTS     = 11,
    parameter int PLAYERS   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    fleet_placement_checker_if.slave bus
);
    localparam int ENTRY_W = 3 + 2*COORD_W*MAX_CELLS + 4;
    localparam int PW      = (PLAYERS > 2) ? $clog2(PLAYERS) : 1;
    localparam int AW      = $clog2(SLOTS);
    localparam int CW      = $clog2(SLOTS + 1);
    localparam int XW      = COORD_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_SCAN, S_WRITE, S_RESP} state_t;
    typedef enum logic [1:0] {R_OK, R_BORDER, R_OVERLAP, R_FULL} res_t;

    state_t             state, state_nxt;
    res_t               res, res_nxt;
    logic [2:0]         tipo;
    logic               dir;
    logic [1:0]         orient;
    logic [COORD_W-1:0] ax, ay;
    logic [PW-1:0]      player;
    logic [CW-1:0]      used [PLAYERS];
    logic [CW-1:0]      used_p;
    logic [CW-1:0]      scan_cnt, scan_cnt_nxt;
    logic               hit, hit_nxt, clear_pend;

    logic [XW-1:0]      cx [MAX_CELLS];
    logic [XW-1:0]      cy [MAX_CELLS];
    logic [3:0]         len;
    logic               border;
    logic               cur_hit;
    logic [ENTRY_W-1:0] entry;
    logic [3:0]         scnt;
    logic               unused_rd_type;

    assign used_p         = used[player];
    assign unused_rd_type = ^bus.rd_data[2:0];

    // Cells carry one extra bit so x-1 / y-1 at 0 wraps high and fails the border test.
    always_comb begin
        for (int i = 0; i < MAX_CELLS; i++) begin
            cx[i] = '0;
            cy[i] = '0;
        end
        len = 4'd0;
        case (tipo)
            3'd0, 3'd1, 3'd3, 3'd4: begin
                len = (tipo == 3'd0) ? 4'd5 : (tipo == 3'd1) ? 4'd4 : (tipo == 3'd3) ? 4'd2 : 4'd1;
                for (int i = 0; i < MAX_CELLS; i++) begin
                    if (4'(i) < len) begin
                        cx[i] = dir ? {1'b0, ax} : {1'b0, ax} + XW'(i);
                        cy[i] = dir ? {1'b0, ay} + XW'(i) : {1'b0, ay};
                    end
                end
            end
            3'd2: begin
                len   = 4'd3;
                cx[0] = {1'b0, ax};
                cy[0] = {1'b0, ay};
                case (orient)
                    2'd0: begin
                        cx[1] = {1'b0, ax} + XW'(1); cy[1] = {1'b0, ay} + XW'(1);
                        cx[2] = {1'b0, ax} + XW'(2); cy[2] = {1'b0, ay};
                    end
                    2'd1: begin
                        cx[1] = {1'b0, ax} + XW'(1); cy[1] = {1'b0, ay} - XW'(1);
                        cx[2] = {1'b0, ax} + XW'(2); cy[2] = {1'b0, ay};
                    end
                    2'd2: begin
                        cx[1] = {1'b0, ax} + XW'(1); cy[1] = {1'b0, ay} + XW'(1);
                        cx[2] = {1'b0, ax};          cy[2] = {1'b0, ay} + XW'(2);
                    end
                    default: begin
                        cx[1] = {1'b0, ax} - XW'(1); cy[1] = {1'b0, ay} + XW'(1);
                        cx[2] = {1'b0, ax};          cy[2] = {1'b0, ay} + XW'(2);
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        border = (tipo > 3'd4);
        entry  = '0;
        entry[2:0] = tipo;
        for (int i = 0; i < MAX_CELLS; i++) begin
            if (4'(i) < len) begin
                if (cx[i] >= XW'(BOARD_DIM) || cy[i] >= XW'(BOARD_DIM))
                    border = 1'b1;
                entry[3 + 2*COORD_W*i +: COORD_W]           = cx[i][COORD_W-1:0];
                entry[3 + 2*COORD_W*i + COORD_W +: COORD_W] = cy[i][COORD_W-1:0];
            end
        end
        entry[ENTRY_W-1 -: 4] = len;
    end

`ifdef ADJACENCY_CHECK_EN
    function automatic logic near(input logic [XW-1:0] a, input logic [XW-1:0] b);
        return (a == b) || (a == b + XW'(1)) || (b == a + XW'(1));
    endfunction
`endif

    always_comb begin
        cur_hit = 1'b0;
        scnt    = bus.rd_data[ENTRY_W-1 -: 4];
        for (int i = 0; i < MAX_CELLS; i++) begin
            for (int j = 0; j < MAX_CELLS; j++) begin
                if (4'(i) < scnt && 4'(j) < len) begin
`ifdef ADJACENCY_CHECK_EN
                    if (near({1'b0, bus.rd_data[3 + 2*COORD_W*i +: COORD_W]}, cx[j]) &&
                        near({1'b0, bus.rd_data[3 + 2*COORD_W*i + COORD_W +: COORD_W]}, cy[j]))
                        cur_hit = 1'b1;
`else
                    if ({1'b0, bus.rd_data[3 + 2*COORD_W*i +: COORD_W]} == cx[j] &&
                        {1'b0, bus.rd_data[3 + 2*COORD_W*i + COORD_W +: COORD_W]} == cy[j])
                        cur_hit = 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        state_nxt           = state;
        res_nxt             = res;
        scan_cnt_nxt        = scan_cnt;
        hit_nxt             = hit;
        bus.req_ready       = 1'b0;
        bus.rd_player       = '0;
        bus.rd_addr         = '0;
        bus.mem_we          = 1'b0;
        bus.mem_wr_player   = '0;
        bus.mem_wr_addr     = '0;
        bus.mem_wr_data     = '0;
        bus.rsp_valid       = 1'b0;
        bus.rsp_ok          = 1'b0;
        bus.rsp_err_border  = 1'b0;
        bus.rsp_err_overlap = 1'b0;
        bus.rsp_err_full    = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = S_EXPAND;
            end
            S_EXPAND: begin
                scan_cnt_nxt = '0;
                hit_nxt      = 1'b0;
                if (border) begin
                    res_nxt = R_BORDER; state_nxt = S_RESP;
                end else if (used_p >= CW'(SLOTS)) begin
                    res_nxt = R_FULL; state_nxt = S_RESP;
                end else begin
                    // An empty fleet still spends one SCAN cycle so success latency stays used+4.
                    res_nxt = R_OK; state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                bus.rd_player = player;
                if (scan_cnt < used_p) bus.rd_addr = AW'(scan_cnt);
                // Data for address k-1 returns while address k is issued.
                if (scan_cnt != '0 && cur_hit) hit_nxt = 1'b1;
                if (scan_cnt == used_p) begin
                    if (hit_nxt) begin
                        res_nxt = R_OVERLAP; state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WRITE;
                    end
                end else begin
                    scan_cnt_nxt = scan_cnt + CW'(1);
                end
            end
            S_WRITE: begin
                bus.mem_we        = 1'b1;
                bus.mem_wr_player = player;
                bus.mem_wr_addr   = AW'(used_p);
                bus.mem_wr_data   = entry;
                state_nxt         = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid       = 1'b1;
                bus.rsp_ok          = (res == R_OK);
                bus.rsp_err_border  = (res == R_BORDER);
                bus.rsp_err_overlap = (res == R_OVERLAP);
                bus.rsp_err_full    = (res == R_FULL);
                state_nxt           = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            res        <= R_OK;
            scan_cnt   <= '0;
            hit        <= 1'b0;
            clear_pend <= 1'b0;
            tipo       <= '0;
            dir        <= 1'b0;
            orient     <= '0;
            ax         <= '0;
            ay         <= '0;
            player     <= '0;
            for (int p = 0; p < PLAYERS; p++) used[p] <= '0;
        end else begin
            state    <= state_nxt;
            res      <= res_nxt;
            scan_cnt <= scan_cnt_nxt;
            hit      <= hit_nxt;
            if (state == S_IDLE && bus.req_valid) begin
                tipo   <= bus.req_tipo;
                dir    <= bus.req_dir;
                orient <= bus.req_orient;
                ax     <= bus.req_x;
                ay     <= bus.req_y;
                player <= bus.req_player;
            end
            if (state == S_WRITE) used[player] <= used_p + CW'(1);
            if (clear && state != S_IDLE && state != S_RESP) clear_pend <= 1'b1;
            // A clear seen while busy waits for RESP so the in-flight write is not lost.
            if ((clear && state == S_IDLE) || (state == S_RESP && (clear || clear_pend))) begin
                for (int p = 0; p < PLAYERS; p++) used[p] <= '0;
                clear_pend <= 1'b0;
            end
        end
    end
endmodule
